matmul_engine: RTL

Parametrised hardware matrix-multiply sequencer. It computes C = A x B for runtime dimensions m x n by n x p, with a dedicated multiply-accumulate path instead of instruction-driven microcode. It masters the same single-port synchronous data RAM as the processor core, using a 1-cycle read latency. It sits beside the core, which launches it with start/done and base addresses.

---
 rtl/matmul_pkg.sv | 24 ++
 rtl/matmul_mac.sv | 40 ++++
 rtl/matmul_engine.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    MAC  = 3'd3,
    WR_C = 3'd4,
    DONE = 3'd5
  } state_e;

  // Wide enough for any element width in use; callers slice the low bits.
  localparam logic [63:0] SAT_ONES = '1;

  function automatic int dim_width(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

  function automatic int acc_width(input int data_w, input int max_dim);
    return 2 * data_w + $clog2(max_dim);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate datapath: holds the A operand and the running dot product.
module matmul_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_load,
  input  logic              mac_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [ACC_W-1:0]  acc
);

  logic [DATA_W-1:0]   a_reg_q, a_reg_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    prod    = a_reg_q * b_in;
    a_reg_d = a_load ? a_in : a_reg_q;
    acc_d   = acc_q;
    // The first term of each dot product replaces the previous element's sum.
    if (mac_en) acc_d = (clr ? '0 : acc_q) + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg_q <= '0;
      acc_q   <= '0;
    end else begin
      a_reg_q <= a_reg_d;
      acc_q   <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_engine.sv
// Matrix-multiply sequencer: C = A x B over a shared 1-cycle-latency RAM.
// Optional saturation of results is enabled with the MATMUL_SAT_EN macro.
//
// state | meaning
// IDLE  | waiting for start; memory outputs parked at 0
// RD_A  | present address of A[i][k]
// RD_B  | present address of B[k][j]; capture A[i][k]
// MAC   | accumulate A[i][k]*B[k][j]
// WR_C  | write C[i][j], step j/i
// DONE  | one-cycle done (and err on illegal dims)
module matmul_engine import matmul_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MAX_DIM = 8,
  parameter int DIM_W   = dim_width(MAX_DIM),
  parameter int ACC_W   = acc_width(DATA_W, MAX_DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DIM_W-1:0]  dim_p,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, p_q, p_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] ptr_a_q, ptr_a_d, row_a_q, row_a_d;
  logic [ADDR_W-1:0] ptr_b_q, ptr_b_d, col_b_q, col_b_d, base_b_q, base_b_d;
  logic [ADDR_W-1:0] ptr_c_q, ptr_c_d;
  logic              err_q, err_d;
  logic              dims_bad;
  logic              accept;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] result;

  assign dims_bad = (dim_m == '0) || (dim_m > DIM_W'(MAX_DIM)) ||
                    (dim_n == '0) || (dim_n > DIM_W'(MAX_DIM)) ||
                    (dim_p == '0) || (dim_p > DIM_W'(MAX_DIM));
  assign accept   = (state_q == IDLE) && start;

  // Running pointers: row_a marks A[i][0], col_b marks B[0][j]; C is linear.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    p_d      = p_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    ptr_a_d  = ptr_a_q;
    row_a_d  = row_a_q;
    ptr_b_d  = ptr_b_q;
    col_b_d  = col_b_q;
    base_b_d = base_b_q;
    ptr_c_d  = ptr_c_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d      = dim_m;
          n_d      = dim_n;
          p_d      = dim_p;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          ptr_a_d  = base_a;
          row_a_d  = base_a;
          ptr_b_d  = base_b;
          col_b_d  = base_b;
          base_b_d = base_b;
          ptr_c_d  = base_c;
          err_d    = dims_bad;
          state_d  = dims_bad ? DONE : RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: state_d = MAC;
      MAC: begin
        if (k_q != n_q - DIM_W'(1)) begin
          k_d     = k_q + DIM_W'(1);
          ptr_a_d = ptr_a_q + ADDR_W'(1);
          ptr_b_d = ptr_b_q + ADDR_W'(p_q);
          state_d = RD_A;
        end else begin
          state_d = WR_C;
        end
      end
      WR_C: begin
        k_d     = '0;
        ptr_c_d = ptr_c_q + ADDR_W'(1);
        state_d = RD_A;
        if (j_q == p_q - DIM_W'(1)) begin
          j_d     = '0;
          row_a_d = row_a_q + ADDR_W'(n_q);
          ptr_a_d = row_a_q + ADDR_W'(n_q);
          col_b_d = base_b_q;
          ptr_b_d = base_b_q;
          if (i_q == m_q - DIM_W'(1)) state_d = DONE;
          else                        i_d     = i_q + DIM_W'(1);
        end else begin
          j_d     = j_q + DIM_W'(1);
          ptr_a_d = row_a_q;
          col_b_d = col_b_q + ADDR_W'(1);
          ptr_b_d = col_b_q + ADDR_W'(1);
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      n_q      <= '0;
      p_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      ptr_a_q  <= '0;
      row_a_q  <= '0;
      ptr_b_q  <= '0;
      col_b_q  <= '0;
      base_b_q <= '0;
      ptr_c_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      p_q      <= p_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      ptr_a_q  <= ptr_a_d;
      row_a_q  <= row_a_d;
      ptr_b_q  <= ptr_b_d;
      col_b_q  <= col_b_d;
      base_b_q <= base_b_d;
      ptr_c_q  <= ptr_c_d;
      err_q    <= err_d;
    end
  end

  matmul_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_load (state_q == RD_B),
    .mac_en (state_q == MAC),
    .clr    (k_q == '0),
    .a_in   (mem_rdata),
    .b_in   (mem_rdata),
    .acc    (acc)
  );

`ifdef MATMUL_SAT_EN
  logic acc_sat;
  logic ovf_q, ovf_d;

  assign acc_sat = |acc[ACC_W-1:DATA_W];
  assign result  = acc_sat ? SAT_ONES[DATA_W-1:0] : acc[DATA_W-1:0];

  always_comb begin
    ovf_d = ovf_q;
    if (accept)                              ovf_d = 1'b0;
    else if ((state_q == WR_C) && acc_sat)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_acc_hi;
  logic unused_accept;

  assign unused_acc_hi = |acc[ACC_W-1:DATA_W];
  assign unused_accept = accept;
  assign result        = acc[DATA_W-1:0];
  assign ovf           = 1'b0;
`endif

  // Memory outputs decode from registered state so reset clears them at once.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state_q)
      RD_A: mem_addr = ptr_a_q;
      RD_B: mem_addr = ptr_b_q;
      WR_C: begin
        mem_addr  = ptr_c_q;
        mem_wdata = result;
        mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = (state_q == DONE) && err_q;

endmodule
